// File: rtl/bcd_add_if.sv
// Digit-level bus for the registered BCD adder: operands and carry-in toward
// the adder, corrected digit, decimal carry and error flag back out.
interface bcd_add_if;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] sum;
  logic       carry;
  logic       err;

  modport master (
    output a, b, cin,
    input  sum, carry, err
  );

  modport slave (
    input  a, b, cin,
    output sum, carry, err
  );
endinterface

// File: rtl/bcd_add.sv
// Single-digit BCD adder with registered outputs. Chain carry into the next
// digit's cin to build multi-digit decimal adders (one cycle per digit).
module bcd_add (
  input  logic      clk,
  input  logic      rst,
  bcd_add_if.slave  bus
);

  logic [4:0] binSum;
  logic [3:0] sum_d, sum_q;
  logic       carry_d, carry_q;
  logic       err_d, err_q;

  // Out-of-range digits still take the normal arithmetic path; err is their only marker.
  always_comb begin
    binSum  = {1'b0, bus.a} + {1'b0, bus.b} + {4'b0000, bus.cin};
    sum_d   = binSum[3:0];
    carry_d = 1'b0;
    if (binSum > 5'd9) begin
      sum_d   = binSum[3:0] + 4'd6;
      carry_d = 1'b1;
    end
    err_d = (bus.a > 4'd9) | (bus.b > 4'd9);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= 4'd0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_bcd_add.sv
// Scoreboard bench for bcd_add: the driver queues the expected registered result
// for every cycle it drives, and a monitor checks one entry after each rising edge.
module tb_bcd_add;

  typedef struct packed {
    logic [3:0] sum;
    logic       carry;
    logic       err;
  } expT;

  logic clk;
  logic rst;
  bcd_add_if bus ();

  bcd_add dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  expT   expQ[$];
  string nameQ[$];
  int    nVectors;
  int    nFails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic expT refModel(input logic [3:0] a, input logic [3:0] b,
                                   input logic cin, input logic rstIn);
    expT r;
    int  s;
    s = int'(a) + int'(b) + int'(cin);
    r.err = (a > 4'd9) || (b > 4'd9);
    if (s >= 10) begin
      r.sum   = 4'((s - 10) % 16);
      r.carry = 1'b1;
    end else begin
      r.sum   = 4'(s);
      r.carry = 1'b0;
    end
    if (rstIn) r = '0;
    return r;
  endfunction

  // Drives one cycle of inputs at the falling edge and queues what must appear after the next rising edge.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic cin,
                               input logic rstIn, input expT want, input string name);
    @(negedge clk);
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
    rst     = rstIn;
    expQ.push_back(want);
    nameQ.push_back(name);
  endtask

  task automatic checkOutput(input expT want, input string name);
    nVectors++;
    if (bus.sum !== want.sum || bus.carry !== want.carry || bus.err !== want.err) begin
      nFails++;
      $display("[TB] FAIL %s: got sum=%0d carry=%b err=%b, want sum=%0d carry=%b err=%b",
               name, bus.sum, bus.carry, bus.err, want.sum, want.carry, want.err);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (expQ.size() > 0) checkOutput(expQ.pop_front(), nameQ.pop_front());
  end

  initial begin
    logic [3:0] sa, sb;
    logic       sc, sr;
    nVectors = 0;
    nFails   = 0;
    rst      = 1'b1;
    bus.a    = 4'd0;
    bus.b    = 4'd0;
    bus.cin  = 1'b0;

    applyStimulus(4'd9,  4'd9, 1'b1, 1'b1, '{4'd0, 1'b0, 1'b0}, "reset0");
    applyStimulus(4'd9,  4'd9, 1'b1, 1'b1, '{4'd0, 1'b0, 1'b0}, "reset1");
    applyStimulus(4'd3,  4'd4, 1'b0, 1'b0, '{4'd7, 1'b0, 1'b0}, "3+4");
    applyStimulus(4'd4,  4'd5, 1'b0, 1'b0, '{4'd9, 1'b0, 1'b0}, "4+5");
    applyStimulus(4'd5,  4'd5, 1'b0, 1'b0, '{4'd0, 1'b1, 1'b0}, "5+5");
    applyStimulus(4'd9,  4'd0, 1'b1, 1'b0, '{4'd0, 1'b1, 1'b0}, "9+0+1");
    applyStimulus(4'd9,  4'd9, 1'b1, 1'b0, '{4'd9, 1'b1, 1'b0}, "9+9+1");
    applyStimulus(4'd15, 4'd15, 1'b1, 1'b0, '{4'd5, 1'b1, 1'b1}, "15+15+1");
    applyStimulus(4'd10, 4'd0, 1'b0, 1'b0, '{4'd0, 1'b1, 1'b1}, "10+0");
    applyStimulus(4'd12, 4'd0, 1'b0, 1'b0, '{4'd2, 1'b1, 1'b1}, "12+0");
    applyStimulus(4'd0,  4'd0, 1'b0, 1'b0, '{4'd0, 1'b0, 1'b0}, "0+0");

    sa = 4'd0;
    sb = 4'd9;
    sc = 1'b0;
    for (int i = 0; i < 100; i++) begin
      sr = (i == 50);
      applyStimulus(sa, sb, sc, sr, refModel(sa, sb, sc, sr), sr ? "sweepReset" : "sweep");
      sa = sa + 4'd1;
      if (i % 2 == 1) sb = sb - 4'd1;
      if (i % 4 == 3) sc = ~sc;
    end

    for (int k = 0; k < 10 && expQ.size() > 0; k++) @(posedge clk);
    #2;
    if (expQ.size() > 0) begin
      nFails++;
      $display("[TB] FAIL drain: %0d results still pending, want 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFails);
    $finish;
  end

endmodule

// File: doc/bcd_add.md
# bcd_add

Single-digit registered BCD adder. It adds two 4-bit BCD digits plus a carry-in and produces a corrected BCD digit and a decimal carry-out. Results are registered with one-cycle latency. It is the per-digit building block for multi-digit decimal adders: chain `carry` of one digit into `cin` of the next.

## Interface

- No parameters; digit width is fixed at 4 bits.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `a`  input  4  addend digit, BCD 0–9 nominal; 10–15 accepted and flagged.
- `b`  input  4  addend digit, same rules as `a`.
- `cin`  input  1  decimal carry-in from the lower digit.
- `sum`  output  4  registered corrected BCD sum digit.
- `carry`  output  1  registered decimal carry-out.
- `err`  output  1  registered flag; 1 when the sampled `a` or `b` exceeded 9.

## Operation

- Binary stage: `s = a + b + cin`, computed 5 bits wide (range 0–31, no overflow).
- Decimal correction, applied when `s > 9`:
  - `sum_next = (s + 6)[3:0]`
  - `carry_next = 1`
- When `s <= 9`:
  - `sum_next = s[3:0]`
  - `carry_next = 0`
- `err_next = (a > 9) | (b > 9)`.
- Invalid digits still go through the same arithmetic. They are not saturated and not forced to zero; `err` is the only indication. Examples:
  - 15+15+1 → s=31 → `sum`=5, `carry`=1, `err`=1.
  - 12+0+0 → s=12 → `sum`=2, `carry`=1, `err`=1.
- There is no internal state beyond the three output registers. Each cycle is independent, with no accumulation and no handshake.
- Every output combination is reachable only via the rules above. With valid digits, `sum` is always 0–9.

## Timing

- On the rising edge of `clk`:
  - If `rst`=1: `sum`←0, `carry`←0, `err`←0.
  - Otherwise: `sum`←`sum_next`, `carry`←`carry_next`, `err`←`err_next`.
- Reset value of every output is 0. `rst` has priority over any input on the same edge.
- Latency is 1 cycle. Inputs sampled at edge N appear on the outputs after edge N and hold until edge N+1.
- Throughput is one addition per clock. Inputs may change every cycle, and there is no valid/ready signalling.
- Reset mid-operation: the result of the inputs sampled on the reset edge is discarded. The first post-reset result appears one cycle after the first edge with `rst`=0.
- Outputs change only on clock edges and never glitch combinationally.
- Carry-chain use: the registered `carry` feeds the next digit one cycle later. A combinational ripple across digits is outside this block.
- `a`, `b` and `cin` must meet setup/hold to `clk`. The critical path is the 5-bit add, then compare-to-9, then add-6, into the register.

## Test plan

- Reset: hold `rst`=1 for 2 cycles with a=9, b=9, cin=1 applied. Required: `sum`=0, `carry`=0, `err`=0 throughout; first real result appears one cycle after `rst` drops.
- No correction: a=3, b=4, cin=0. Required next cycle: `sum`=7, `carry`=0, `err`=0. Also a=4, b=5, cin=0 gives `sum`=9, `carry`=0.
- Boundary at ten: a=5, b=5, cin=0 gives `sum`=0, `carry`=1. Also a=9, b=0, cin=1 gives `sum`=0, `carry`=1.
- Maximum valid: a=9, b=9, cin=1 (s=19) gives `sum`=9, `carry`=1, `err`=0.
- Invalid digits: a=15, b=15, cin=1 gives `sum`=5, `carry`=1, `err`=1. Also a=10, b=0, cin=0 gives `sum`=0, `carry`=1, `err`=1.
- Sweep: increment `a` each cycle, decrement `b` every two cycles, toggle `cin` every four cycles, wrapping modulo 16, for 100 cycles. Compare every output against a reference model delayed by one cycle. Assert `rst` for one cycle mid-sweep and check that the outputs show zero on the following cycle.
